// File: rtl/priority_scanner_if.sv
// -----------------------------------------------------------------------------
// priority_scanner_if
// Handshake bundle between a request producer / index consumer and
// priority_scanner.
//   in_valid / in_ready / in_data      : request vector handshake
//   out_valid / out_ready              : index beat handshake
//   out_index / out_last / out_null    : beat payload
//   flush                              : synchronous abort of pending bits
// Modports: master = producer/consumer side, slave = priority_scanner side.
// -----------------------------------------------------------------------------
interface priority_scanner_if #(
   parameter int WIDTH = 16,
   parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [IDXW-1:0]  out_index;
   logic             out_last;
   logic             out_null;
   logic             flush;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_index, out_last, out_null
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_index, out_last, out_null
   );
endinterface

// File: rtl/priority_scanner.sv
// -----------------------------------------------------------------------------
// priority_scanner
// Accepts a multi-hot request vector and emits the index of every set bit,
// one per beat, highest-first (MSB_FIRST=1) or lowest-first (MSB_FIRST=0).
// An all-zero vector produces a single "null" beat. A new vector may be
// accepted on the cycle the last beat transfers, so there is no bubble.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   sif  : priority_scanner_if.slave (vector in, index beats out, flush)
// -----------------------------------------------------------------------------
module priority_scanner #(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 1,
   parameter int IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   priority_scanner_if.slave  sif
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pending;
   logic             r_null;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_pending_nxt;
   logic             w_null_nxt;
   logic [IDXW-1:0]  w_sel;
   logic [WIDTH-1:0] w_sel_mask;
   logic             w_single;
   logic             w_out_valid;
   logic             w_out_last;
   logic             w_in_ready;
   logic             w_out_xfer;

   // Single-cycle find-first-set over pending. The loop runs in the direction
   // where the last match seen is the highest-priority bit.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_sel = '0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++)
            if (r_pending[i]) w_sel = IDXW'(i);
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--)
            if (r_pending[i]) w_sel = IDXW'(i);
      end
   end

   assign w_sel_mask = WIDTH'(1) << w_sel;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign w_single = (r_pending != '0) &&
                     ((r_pending & (r_pending - WIDTH'(1))) == '0);

   // Outputs are decoded from state only; rst/flush suppress the beat so a
   // beat is never counted as transferred during an abort cycle.
   assign w_out_valid = (r_state == SCAN) && !rst && !sif.flush;
   assign w_out_last  = (r_state == SCAN) && (w_single || r_null);
   assign w_out_xfer  = w_out_valid && sif.out_ready;
   assign w_in_ready  = !rst && !sif.flush &&
                        ((r_state == IDLE) || (w_out_xfer && w_out_last));

   assign sif.out_valid = w_out_valid;
   assign sif.out_last  = w_out_last;
   assign sif.out_null  = (r_state == SCAN) && r_null;
   assign sif.out_index = r_null ? '0 : w_sel;
   assign sif.in_ready  = w_in_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_null_nxt    = r_null;

      if (w_out_xfer) begin
         w_pending_nxt = r_pending & ~w_sel_mask;
         if (w_out_last) begin
            w_state_nxt = IDLE;
            w_null_nxt  = 1'b0;
         end
      end

      // A vector accepted on the last-beat cycle overrides the return to IDLE.
      if (sif.in_valid && w_in_ready) begin
         w_state_nxt   = SCAN;
         w_pending_nxt = sif.in_data;
         w_null_nxt    = (sif.in_data == '0);
      end

      if (sif.flush) begin
         w_state_nxt   = IDLE;
         w_pending_nxt = '0;
         w_null_nxt    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_null    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_null    <= w_null_nxt;
      end
   end

endmodule
